// File: rtl/pattern_detector.sv
// Serial pattern detector: matches a loadable PAT_W-bit pattern against the
// most recent valid input bits, with selectable overlapping/non-overlapping
// detection and a saturating match counter.
module pattern_detector #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             x,
  input  logic             valid,
  input  logic             load,
  input  logic [PAT_W-1:0] pat,
  input  logic             overlap,
  input  logic             clr,
  output logic             y,
  output logic             armed,
  output logic [CNT_W-1:0] count
);

  // Fill counter must represent 0..PAT_W inclusive.
  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic {
    UNARMED = 1'b0,
    ARMED   = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic               armed_q, armed_d;
  logic               y_q, y_d;
  logic [PAT_W-1:0]   pat_q, pat_d;
  logic [PAT_W-1:0]   hist_q, hist_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  // Candidate history/fill after accepting the current bit.
  logic [PAT_W-1:0]   hist_shift;
  logic [FILL_W-1:0]  fill_shift;
  logic               match;

  // Saturating increment of the match counter (no wrap-around).
  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] c);
    if (c == CNT_MAX) return c;
    return c + 1'b1;
  endfunction

  // Fill count grows with each accepted bit but never exceeds PAT_W.
  function automatic logic [FILL_W-1:0] fill_sat_inc(input logic [FILL_W-1:0] f);
    if (f == FILL_FULL) return f;
    return f + 1'b1;
  endfunction

  // Newest bit enters at the LSB so pat[PAT_W-1] lines up with the oldest bit.
  function automatic logic [PAT_W-1:0] shift_in(input logic [PAT_W-1:0] h,
                                                 input logic             b);
    return {h[PAT_W-2:0], b};
  endfunction

  // Next-state logic for the FSM, history, fill, counter and match pulse.
  always_comb begin
    state_d    = state_q;
    pat_d      = pat_q;
    hist_d     = hist_q;
    fill_d     = fill_q;
    cnt_d      = cnt_q;
    y_d        = 1'b0;
    hist_shift = shift_in(hist_q, x);
    fill_shift = fill_sat_inc(fill_q);
    match      = 1'b0;

    if (load) begin
      // Load wins over a coincident valid bit; that bit is dropped.
      state_d = ARMED;
      pat_d   = pat;
      hist_d  = '0;
      fill_d  = '0;
    end else if (state_q == ARMED && valid) begin
      match  = (hist_shift == pat_q) && (fill_shift == FILL_FULL);
      hist_d = hist_shift;
      fill_d = fill_shift;
      if (match) begin
        y_d   = 1'b1;
        cnt_d = cnt_sat_inc(cnt_q);
        // Non-overlapping mode demands PAT_W fresh bits for the next match.
        if (!overlap) fill_d = '0;
      end
    end

    // Clear beats a simultaneous match increment, in either state.
    if (clr) cnt_d = '0;

    armed_d = (state_d == ARMED);
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= UNARMED;
      armed_q <= 1'b0;
      y_q     <= 1'b0;
      pat_q   <= '0;
      hist_q  <= '0;
      fill_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      armed_q <= armed_d;
      y_q     <= y_d;
      pat_q   <= pat_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
    end
  end

  assign y     = y_q;
  assign armed = armed_q;
  assign count = cnt_q;

endmodule

// File: tb/tb_pattern_detector.sv
// Testbench for pattern_detector: directed vector table, hand-written corner
// sequences, and randomized stimulus against a queue-based reference model.
module tb_pattern_detector;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;

  // DUT1: PAT_W=4, CNT_W=8
  logic       x, valid, load, overlap, clr;
  logic [3:0] pat;
  logic       y, armed;
  logic [7:0] count;

  // DUT2: PAT_W=2, CNT_W=2 (saturation corner)
  logic       x2, valid2, load2, overlap2, clr2;
  logic [1:0] pat2;
  logic       y2, armed2;
  logic [1:0] count2;

  int total = 0;
  int bad   = 0;

  pattern_detector #(.PAT_W(4), .CNT_W(8)) dut (
    .CLK(CLK), .RST(RST), .x(x), .valid(valid), .load(load), .pat(pat),
    .overlap(overlap), .clr(clr), .y(y), .armed(armed), .count(count)
  );

  pattern_detector #(.PAT_W(2), .CNT_W(2)) dut2 (
    .CLK(CLK), .RST(RST), .x(x2), .valid(valid2), .load(load2), .pat(pat2),
    .overlap(overlap2), .clr(clr2), .y(y2), .armed(armed2), .count(count2)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       ld;
    logic [3:0] p;
    logic       v;
    logic       xb;
    logic       ov;
    logic       cl;
    logic       ey;
    logic       ea;
    logic [7:0] ec;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic ld, input logic [3:0] p, input logic v,
                     input logic xb, input logic ov, input logic cl,
                     input logic ey, input logic ea, input logic [7:0] ec);
    vec_t r;
    r.ld = ld; r.p = p; r.v = v; r.xb = xb; r.ov = ov; r.cl = cl;
    r.ey = ey; r.ea = ea; r.ec = ec;
    tbl.push_back(r);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Advance one clock and settle past the edge before sampling.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive1(input logic ld, input logic [3:0] p, input logic v,
                        input logic xb, input logic ov, input logic cl);
    load = ld; pat = p; valid = v; x = xb; overlap = ov; clr = cl;
  endtask

  // Reference model state (DUT1): bits received since last load/reset/
  // non-overlapping match, trimmed to the last 4.
  bit        m_armed;
  int        m_pat;
  bit        m_q[$];
  int        m_cnt;
  bit        m_y;

  task automatic model_reset();
    m_armed = 0; m_pat = 0; m_q.delete(); m_cnt = 0; m_y = 0;
  endtask

  task automatic model_step(input bit ld, input int p, input bit v,
                            input bit xb, input bit ov, input bit cl);
    int val;
    m_y = 0;
    if (ld) begin
      m_armed = 1;
      m_pat   = p;
      m_q.delete();
    end else if (m_armed && v) begin
      m_q.push_back(xb);
      if (m_q.size() > 4) void'(m_q.pop_front());
      if (m_q.size() == 4) begin
        val = 0;
        foreach (m_q[i]) val = val * 2 + int'(m_q[i]);
        if (val == m_pat) begin
          m_y = 1;
          if (m_cnt < 255) m_cnt++;
          if (!ov) m_q.delete();
        end
      end
    end
    if (cl) m_cnt = 0;
  endtask

  initial begin
    int ycnt [6];
    int ey2  [6];

    x = 0; valid = 0; load = 0; overlap = 0; clr = 0; pat = '0;
    x2 = 0; valid2 = 0; load2 = 0; overlap2 = 0; clr2 = 0; pat2 = '0;

    // Unarmed: stream ignored, clr harmless
    add(0, 4'h0, 1, 1, 0, 0, 0, 0, 0);
    add(0, 4'h0, 1, 0, 0, 0, 0, 0, 0);
    add(0, 4'h0, 1, 1, 0, 0, 0, 0, 0);
    add(0, 4'h0, 1, 1, 0, 0, 0, 0, 0);
    add(0, 4'h0, 0, 0, 0, 1, 0, 0, 0);
    // Overlapping: 1,0,1,1,0,1,1 -> matches on bits 4 and 7
    add(1, 4'b1011, 0, 0, 1, 0, 0, 1, 0);
    add(0, 4'h0, 1, 1, 1, 0, 0, 1, 0);
    add(0, 4'h0, 1, 0, 1, 0, 0, 1, 0);
    add(0, 4'h0, 1, 1, 1, 0, 0, 1, 0);
    add(0, 4'h0, 1, 1, 1, 0, 1, 1, 1);
    add(0, 4'h0, 1, 0, 1, 0, 0, 1, 1);
    add(0, 4'h0, 1, 1, 1, 0, 0, 1, 1);
    add(0, 4'h0, 1, 1, 1, 0, 1, 1, 2);
    // Non-overlapping: same stream -> only bit 4 matches; load keeps count
    add(1, 4'b1011, 0, 0, 0, 0, 0, 1, 2);
    add(0, 4'h0, 1, 1, 0, 0, 0, 1, 2);
    add(0, 4'h0, 1, 0, 0, 0, 0, 1, 2);
    add(0, 4'h0, 1, 1, 0, 0, 0, 1, 2);
    add(0, 4'h0, 1, 1, 0, 0, 1, 1, 3);
    add(0, 4'h0, 1, 0, 0, 0, 0, 1, 3);
    add(0, 4'h0, 1, 1, 0, 0, 0, 1, 3);
    add(0, 4'h0, 1, 1, 0, 0, 0, 1, 3);
    // Gap of valid=0 inside a match
    add(1, 4'b1011, 0, 0, 1, 0, 0, 1, 3);
    add(0, 4'h0, 1, 1, 1, 0, 0, 1, 3);
    add(0, 4'h0, 1, 0, 1, 0, 0, 1, 3);
    add(0, 4'h0, 1, 1, 1, 0, 0, 1, 3);
    add(0, 4'h0, 0, 1, 1, 0, 0, 1, 3);
    add(0, 4'h0, 0, 0, 1, 0, 0, 1, 3);
    add(0, 4'h0, 0, 1, 1, 0, 0, 1, 3);
    add(0, 4'h0, 1, 1, 1, 0, 1, 1, 4);
    add(0, 4'h0, 0, 1, 1, 0, 0, 1, 4);
    // Load with coincident valid: the bit is discarded
    add(1, 4'b1011, 1, 1, 1, 0, 0, 1, 4);
    add(0, 4'h0, 1, 0, 1, 0, 0, 1, 4);
    add(0, 4'h0, 1, 1, 1, 0, 0, 1, 4);
    add(0, 4'h0, 1, 1, 1, 0, 0, 1, 4);
    // Overlap changed mid-stream
    add(1, 4'b1011, 0, 0, 1, 0, 0, 1, 4);
    add(0, 4'h0, 1, 1, 1, 0, 0, 1, 4);
    add(0, 4'h0, 1, 0, 1, 0, 0, 1, 4);
    add(0, 4'h0, 1, 1, 1, 0, 0, 1, 4);
    add(0, 4'h0, 1, 1, 1, 0, 1, 1, 5);
    add(0, 4'h0, 1, 0, 0, 0, 0, 1, 5);
    add(0, 4'h0, 1, 1, 0, 0, 0, 1, 5);
    add(0, 4'h0, 1, 1, 0, 0, 1, 1, 6);
    add(0, 4'h0, 1, 0, 1, 0, 0, 1, 6);
    add(0, 4'h0, 1, 1, 1, 0, 0, 1, 6);
    add(0, 4'h0, 1, 1, 1, 0, 0, 1, 6);
    // clr in armed state
    add(0, 4'h0, 0, 0, 1, 1, 0, 1, 0);

    // Asynchronous reset without a clock edge
    #2 RST = 1'b0;
    #2;
    chk("rst_y", int'(y), 0);
    chk("rst_armed", int'(armed), 0);
    chk("rst_count", int'(count), 0);
    tick();
    tick();
    RST = 1'b1;

    // Directed table
    foreach (tbl[i]) begin
      drive1(tbl[i].ld, tbl[i].p, tbl[i].v, tbl[i].xb, tbl[i].ov, tbl[i].cl);
      tick();
      chk($sformatf("tbl%0d_y", i), int'(y), int'(tbl[i].ey));
      chk($sformatf("tbl%0d_armed", i), int'(armed), int'(tbl[i].ea));
      chk($sformatf("tbl%0d_count", i), int'(count), int'(tbl[i].ec));
    end
    drive1(0, 4'h0, 0, 0, 0, 0);

    // Narrow counter saturation with clr racing a match (DUT2)
    ey2 = '{0, 1, 1, 1, 1, 1};
    ycnt = '{0, 1, 2, 3, 3, 3};
    load2 = 1; pat2 = 2'b11; overlap2 = 1;
    tick();
    chk("sat_armed", int'(armed2), 1);
    load2 = 0; valid2 = 1; x2 = 1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("sat%0d_y", k), int'(y2), ey2[k]);
      chk($sformatf("sat%0d_count", k), int'(count2), ycnt[k]);
    end
    clr2 = 1;
    tick();
    chk("satclr_y", int'(y2), 1);
    chk("satclr_count", int'(count2), 0);
    clr2 = 0;
    tick();
    chk("satpost_count", int'(count2), 1);
    valid2 = 0;

    // Reset mid-sequence discards partial history and arming
    drive1(1, 4'b1011, 0, 0, 1, 0); tick();
    drive1(0, 4'h0, 1, 1, 1, 0);    tick();
    drive1(0, 4'h0, 1, 0, 1, 0);    tick();
    drive1(0, 4'h0, 1, 1, 1, 0);    tick();
    drive1(0, 4'h0, 0, 0, 1, 0);
    RST = 1'b0;
    #1;
    chk("midrst_armed", int'(armed), 0);
    chk("midrst_count", int'(count), 0);
    tick();
    RST = 1'b1;
    drive1(0, 4'h0, 1, 1, 1, 0);    tick();
    chk("midrst_noload_armed", int'(armed), 0);
    chk("midrst_noload_y", int'(y), 0);
    drive1(1, 4'b1011, 0, 0, 1, 0); tick();
    drive1(0, 4'h0, 1, 1, 1, 0);    tick();
    chk("midrst_y", int'(y), 0);
    chk("midrst_armed2", int'(armed), 1);
    chk("midrst_count2", int'(count), 0);

    // Randomized run against the reference model
    drive1(0, 4'h0, 0, 0, 0, 0);
    RST = 1'b0;
    #1;
    tick();
    RST = 1'b1;
    model_reset();
    overlap = 1;
    for (int n = 0; n < 3000; n++) begin
      load  = ($urandom_range(0, 39) == 0);
      pat   = 4'($urandom_range(0, 15));
      valid = ($urandom_range(0, 3) != 0);
      x     = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 49) == 0) overlap = ~overlap;
      clr   = ($urandom_range(0, 299) == 0);
      if (n == 0) load = 1;
      model_step(load, int'(pat), valid, x, overlap, clr);
      tick();
      chk($sformatf("rnd%0d_y", n), int'(y), int'(m_y));
      chk($sformatf("rnd%0d_armed", n), int'(armed), int'(m_armed));
      chk($sformatf("rnd%0d_count", n), int'(count), m_cnt);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pattern_detector.md
PATTERN_DETECTOR -- requirements
Module: pattern_detector

Interface
REQ-001 SHALL have parameter PAT_W, default 4, pattern length in bits (legal range 2..16).
REQ-002 SHALL have parameter CNT_W, default 8, width of the match counter (legal range 1..16).
REQ-003 SHALL have port CLK  input  1  single clock; all state changes on the rising edge.
REQ-004 SHALL have port RST  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port x  input  1  serial data bit.
REQ-006 SHALL have port valid  input  1  x is sampled only when valid=1.
REQ-007 SHALL have port load  input  1  latch a new pattern from pat.
REQ-008 SHALL have port pat  input  PAT_W  pattern; pat[PAT_W-1] matches the oldest (first-received) bit.
REQ-009 SHALL have port overlap  input  1  1 = overlapping matches allowed; 0 = non-overlapping.
REQ-010 SHALL have port clr  input  1  synchronous clear of the match counter.
REQ-011 SHALL have port y  output  1  registered one-cycle match pulse.
REQ-012 SHALL have port armed  output  1  a pattern has been loaded since reset.
REQ-013 SHALL have port count  output  CNT_W  saturating number of matches.

Function
REQ-014 SHALL implement a two-state FSM: UNARMED and ARMED; armed=1 exactly in ARMED.
REQ-015 SHALL move UNARMED->ARMED on any edge with load=1; ARMED SHALL be left only by reset.
REQ-016 On load=1 (either state) SHALL latch pat into the pattern register and set the shift history and fill count to 0.
REQ-017 When load=1 and valid=1 coincide, SHALL discard that x bit, because load has priority.
REQ-018 In UNARMED SHALL ignore valid and x; y stays 0 and count is unchanged.
REQ-019 In ARMED with valid=1 and load=0, SHALL shift x into a PAT_W-bit history (newest bit at LSB) and increment the fill count, saturating at PAT_W.
REQ-020 A match SHALL occur on an edge where the post-shift history equals the pattern register and the post-shift fill equals PAT_W.
REQ-021 y SHALL be 1 for exactly the one cycle following the match edge and 0 otherwise; latency is one cycle from the sampled completing bit.
REQ-022 With overlap=1, the fill count SHALL remain PAT_W after a match, so the next valid bit can complete another match.
REQ-023 With overlap=0, the fill count SHALL be set to 0 on the match edge, so the next match needs PAT_W fresh bits.
REQ-024 overlap SHALL be sampled on each match edge; changing it mid-stream affects only later matches.
REQ-025 Cycles with valid=0 SHALL hold the history, fill count and count, and SHALL force y to 0 next cycle.
REQ-026 On a match edge, count SHALL increment by 1 and saturate at 2^CNT_W-1, with no wrap-around.
REQ-027 clr=1 SHALL set count to 0 at the edge; if clr and a match coincide, count SHALL become 0, clr winning, and y SHALL still pulse.
REQ-028 clr SHALL act in both FSM states; load SHALL NOT modify count.

Reset
REQ-029 RST=0 SHALL immediately, without waiting for CLK, force: state UNARMED, y=0, armed=0, count=0, history=0, fill=0, pattern register=0.
REQ-030 Reset asserted mid-sequence SHALL discard the partial history; after release, a load is required before any match.
REQ-031 Deassertion of RST SHALL take effect at the first rising CLK edge after release.

Verification (PAT_W=4, CNT_W=8 unless noted)
REQ-032 No load, valid=1, x stream 1,0,1,1 -> y never 1, armed=0, count=0.
REQ-033 load pat=1011, overlap=1, then valid bits 1,0,1,1,0,1,1 -> y pulses the cycle after bits 4 and 7; count=2.
REQ-034 Same stream with overlap=0 -> y pulses only after bit 4; count=1.
REQ-035 pat=1011, overlap=1, bits 1,0,1 then valid=0 for 3 cycles, then bit 1 -> y=0 during the gap, then y pulses once; count=1.
REQ-036 CNT_W=2, pat=11, overlap=1, 6 valid ones -> 5 matches; count reads 1,2,3,3,3; then clr coincident with a match -> count=0 and y=1.
REQ-037 RST pulsed low after bits 1,0,1 of pattern 1011, then released, load 1011 and send bit 1 -> no match; armed=1 and count=0.
